// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Produces stall/flush/redirect controls for the IF/ID and ID/EX registers,
// sequences the multi-cycle multiplier in EX and keeps saturating perf counters.
module hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wen,
  input  logic             ex_mem_ren,
  input  logic             ex_mul,
  input  logic             ex_mispredict,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             redirect_valid,
  output logic             mul_start,
  output logic             mul_done,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_mispredict,
  output logic [CNT_W-1:0] cnt_freeze
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  mul_state_t       state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic             mul_start_c, mul_done_c;
  logic             cache_stall, mul_freeze, freeze;
  logic             load_use, mispredict_sel, load_use_sel;
  logic [CNT_W-1:0] cnt_lu_q, cnt_mp_q, cnt_fz_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Multiplier sequencer next state; BUSY counts down even under cache stalls.
  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    mul_start_c = 1'b0;
    mul_done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mul && !cache_stall) begin
          mul_start_c = 1'b1;
          mul_cnt_d   = MUL_CNT_INIT;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mul_cnt_q == 4'd1) state_d = DONE;
        else                   mul_cnt_d = mul_cnt_q - 4'd1;
      end
      DONE: begin
        if (!cache_stall) begin
          mul_done_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier state register; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Hazard priority: freeze, then mispredict squash, then load-use bubble.
  // A mispredict alongside ex_mul is illegal; ex_mul wins if it ever happens.
  always_comb begin
    cache_stall    = icache_stall | dcache_stall;
    mul_freeze     = ((state_q == IDLE) & ex_mul) | (state_q == BUSY);
    freeze         = cache_stall | mul_freeze;
    load_use       = id_valid & ex_mem_ren & ex_reg_wen & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    mispredict_sel = !freeze & ex_mispredict & !ex_mul;
    load_use_sel   = !freeze & !mispredict_sel & load_use;

    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    redirect_valid = 1'b0;
    mul_start      = 1'b0;
    mul_done       = 1'b0;
    if (rst_n) begin
      mul_start = mul_start_c;
      mul_done  = mul_done_c;
      if (freeze) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (mispredict_sel) begin
        flush_id       = 1'b1;
        flush_ex       = 1'b1;
        redirect_valid = 1'b1;
      end else if (load_use_sel) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  // Performance counters: count the event on the edge it is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_lu_q <= '0;
      cnt_mp_q <= '0;
      cnt_fz_q <= '0;
    end else begin
      if (load_use_sel)   cnt_lu_q <= sat_inc(cnt_lu_q);
      if (mispredict_sel) cnt_mp_q <= sat_inc(cnt_mp_q);
      if (freeze)         cnt_fz_q <= sat_inc(cnt_fz_q);
    end
  end

  assign cnt_load_use   = rst_n ? cnt_lu_q : '0;
  assign cnt_mispredict = rst_n ? cnt_mp_q : '0;
  assign cnt_freeze     = rst_n ? cnt_fz_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver applies stimulus, evaluates a
// behavioural model and queues the expected outputs; the monitor pops and
// compares on every falling edge.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wen;
    logic       ren;
    logic       mul;
    logic       mp;
    logic       ic;
    logic       dc;
  } stim_t;

  typedef struct packed {
    logic [8:0]       ctrl;
    logic [CNT_W-1:0] lu;
    logic [CNT_W-1:0] mp;
    logic [CNT_W-1:0] fz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_reg_wen = 1'b0, ex_mem_ren = 1'b0, ex_mul = 1'b0, ex_mispredict = 1'b0;
  logic icache_stall = 1'b0, dcache_stall = 1'b0;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic redirect_valid, mul_start, mul_done;
  logic [CNT_W-1:0] cnt_load_use, cnt_mispredict, cnt_freeze;

  hazard_ctrl #(.MUL_LATENCY(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_mem_ren(ex_mem_ren), .ex_mul(ex_mul),
    .ex_mispredict(ex_mispredict), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .redirect_valid(redirect_valid),
    .mul_start(mul_start), .mul_done(mul_done), .cnt_load_use(cnt_load_use),
    .cnt_mispredict(cnt_mispredict), .cnt_freeze(cnt_freeze)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: a launched multiply is "in flight" until MUL_LAT cycles
  // have elapsed since launch, then retires on the first cache-free cycle.
  bit m_launched = 1'b0;
  int m_age = 0;
  int n_lu = 0, n_mp = 0, n_fz = 0;

  function automatic logic [CNT_W-1:0] clip(input int v);
    return (v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(v);
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit cache, hold, freeze, start, done, lu, mp_sel, lu_sel;
    @(posedge clk);
    #1;
    rst_n = s.rst_n; id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    ex_rd = s.rd; ex_reg_wen = s.wen; ex_mem_ren = s.ren; ex_mul = s.mul;
    ex_mispredict = s.mp; icache_stall = s.ic; dcache_stall = s.dc;
    e = '0;
    if (!s.rst_n) begin
      m_launched = 1'b0; m_age = 0; n_lu = 0; n_mp = 0; n_fz = 0;
    end else begin
      cache  = s.ic | s.dc;
      hold   = m_launched ? (m_age < MUL_LAT) : s.mul;
      freeze = cache | hold;
      start  = !m_launched && s.mul && !cache;
      done   = m_launched && (m_age >= MUL_LAT) && !cache;
      lu     = s.id_valid && s.ren && s.wen && (s.rd != 0) && (s.rd == s.rs1 || s.rd == s.rs2);
      mp_sel = !freeze && s.mp;
      lu_sel = !freeze && !s.mp && lu;
      // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, redirect, start, done}
      if (freeze)      e.ctrl = 9'b1111_000_00;
      else if (mp_sel) e.ctrl = 9'b0000_111_00;
      else if (lu_sel) e.ctrl = 9'b1100_010_00;
      e.ctrl[1] = start;
      e.ctrl[0] = done;
      e.lu = clip(n_lu); e.mp = clip(n_mp); e.fz = clip(n_fz);
      if (start) begin
        m_launched = 1'b1; m_age = 1;
      end else if (done) begin
        m_launched = 1'b0;
      end else if (m_launched && m_age < MUL_LAT) begin
        m_age++;
      end
      n_lu += int'(lu_sel); n_mp += int'(mp_sel); n_fz += int'(freeze);
    end
    exp_q.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    stim_t s;
    s = idle_s();
    s.rst_n = 1'b0;
    for (int i = 0; i < n; i++) drive(s);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b required=%b", name, cyc, act, req);
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    assert (!(ex_mul && ex_mispredict)) else $error("ex_mul and ex_mispredict together");
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                     redirect_valid, mul_start, mul_done}, e.ctrl);
      check("cnt_load_use", 9'(cnt_load_use), 9'(e.lu));
      check("cnt_mispredict", 9'(cnt_mispredict), 9'(e.mp));
      check("cnt_freeze", 9'(cnt_freeze), 9'(e.fz));
    end
  end

  initial begin
    stim_t s;
    int wait_cnt;
    reset_cycles(2);

    // Load-use on rs2, then the same with rd=x0 (no hazard).
    s = idle_s(); s.ren = 1; s.wen = 1; s.rd = 5'd5; s.id_valid = 1; s.rs2 = 5'd5; s.rs1 = 5'd7;
    drive(s);
    drive(idle_s());
    s.rd = 5'd0; s.rs2 = 5'd0;
    drive(s);
    drive(idle_s());

    // Mispredict overriding a simultaneous load-use.
    reset_cycles(1);
    s = idle_s(); s.ren = 1; s.wen = 1; s.rd = 5'd3; s.id_valid = 1; s.rs1 = 5'd3; s.mp = 1;
    drive(s);
    drive(idle_s());

    // Single multiply with ex_mul held until it retires.
    reset_cycles(1);
    s = idle_s(); s.mul = 1;
    for (int i = 0; i < MUL_LAT + 1; i++) drive(s);
    drive(idle_s());

    // Multiply with a D$ miss arriving while the result is due.
    reset_cycles(1);
    for (int i = 0; i < 9; i++) begin
      s = idle_s(); s.mul = 1; s.dc = (i >= 3 && i < 6);
      drive(s);
    end
    drive(idle_s());

    // Back-to-back multiplies.
    reset_cycles(1);
    s = idle_s(); s.mul = 1;
    for (int i = 0; i < 2 * (MUL_LAT + 1) + 1; i++) drive(s);
    drive(idle_s());

    // Mispredict held across an I$ stall, then reset in the middle of a multiply.
    reset_cycles(1);
    s = idle_s(); s.mp = 1; s.ic = 1;
    drive(s); drive(s);
    s.ic = 0;
    drive(s);
    drive(idle_s());
    s = idle_s(); s.mul = 1;
    drive(s); drive(s);
    reset_cycles(1);
    drive(idle_s()); drive(idle_s());

    // Randomised traffic, long enough to saturate the narrow counters.
    for (int i = 0; i < 3000; i++) begin
      s = idle_s();
      s.rst_n    = ($urandom_range(0, 299) != 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.wen = 1'($urandom_range(0, 1));
      s.ren = 1'($urandom_range(0, 1));
      s.mul = ($urandom_range(0, 7) == 0);
      s.mp  = !s.mul && ($urandom_range(0, 5) == 0);
      s.ic  = ($urandom_range(0, 7) == 0);
      s.dc  = ($urandom_range(0, 7) == 0);
      drive(s);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Generates per-stage stall and flush for the IF/ID and ID/EX pipeline registers:
  - load-use interlock
  - branch/jump mispredict squash and redirect
  - global freeze on I$/D$ misses
  - sequencing of the multi-cycle multiplier in EX
- Maintains saturating performance counters for stall and flush events.

Parameters:
MUL_LATENCY, 4, multiplier cycles from mul_start to result valid; legal range 2..15
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
id_valid  in  1  IF/ID register holds a real instruction
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
ex_rd  in  5  rd of instruction in EX
ex_reg_wen  in  1  EX instruction writes rd
ex_mem_ren  in  1  EX instruction is a load
ex_mul  in  1  EX instruction is a multiply
ex_mispredict  in  1  EX resolved branch/jal/jalr target != pred_dest
icache_stall  in  1  I$ miss in progress
dcache_stall  in  1  D$ miss in progress
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register (drives ID stage stall)
stall_mem  out  1  hold EX/MEM register
flush_id  out  1  load bubble into IF/ID
flush_ex  out  1  load bubble into ID/EX (drives ID stage flush)
redirect_valid  out  1  PC takes corrected target from EX this cycle
mul_start  out  1  one-cycle launch pulse to multiplier
mul_done  out  1  multiplier result captured into EX/MEM this cycle
cnt_load_use  out  CNT_W  load-use bubbles inserted
cnt_mispredict  out  CNT_W  mispredict redirects taken
cnt_freeze  out  CNT_W  cycles with global freeze

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE, mul counter=0, all perf counters=0. While rst_n=0 every output is 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE & ex_mul & !cache_stall: mul_start=1, load cnt=MUL_LATENCY-1, go BUSY.
  - IDLE & ex_mul & cache_stall: no start; stay IDLE.
  - BUSY: if cnt==1 go DONE, else cnt-=1. Decrements regardless of cache stalls.
  - DONE & !cache_stall: mul_done=1, go IDLE.
  - DONE & cache_stall: hold DONE, mul_done=0.
  - mul_freeze = (IDLE & ex_mul) | BUSY.
  - A mul therefore occupies EX for exactly MUL_LATENCY+1 cycles when no cache stall occurs.
- Definitions:
  - cache_stall = icache_stall | dcache_stall
  - freeze = cache_stall | mul_freeze
- Priority (combinational outputs), highest first:
  1. freeze: stall_if=stall_id=stall_ex=stall_mem=1. flush_id=flush_ex=redirect_valid=0.
  2. ex_mispredict: flush_id=1, flush_ex=1, redirect_valid=1, all stalls 0. Overrides load-use, since the ID instruction is wrong-path.
  3. load_use: stall_if=stall_id=1, flush_ex=1, stall_ex=stall_mem=0.
     - load_use = id_valid & ex_mem_ren & ex_reg_wen & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  4. Otherwise all outputs 0.
- A mispredict during freeze is not lost: EX is held, so ex_mispredict re-presents after freeze ends. No pending register is needed.
- ex_mul & ex_mispredict simultaneously is illegal; the bench asserts it never occurs. In RTL, ex_mul wins.
- After an ex_mul the next load_use check uses the post-freeze EX contents only; no hazard is evaluated while frozen.
- Perf counters:
  - Increment by 1 on the posedge where the corresponding output condition holds: load_use selected; redirect_valid; freeze.
  - Saturate at all-ones.
  - Registered, so visible the cycle after the event.
- Reset mid-multiply: FSM returns to IDLE immediately, no mul_done; the multiplier is reset by the same rst_n.

Test Plan:
- Load-use: ex_mem_ren=1, ex_reg_wen=1, ex_rd=5, id_valid=1, id_rs2=5 for one cycle -> stall_if=stall_id=flush_ex=1, stall_ex=0; next cycle cnt_load_use=1. Repeat with ex_rd=0 -> no stall.
- Mispredict with simultaneous load_use conditions -> flush_id=flush_ex=redirect_valid=1, stalls 0; cnt_mispredict=1, cnt_load_use=0.
- Mul, MUL_LATENCY=4, ex_mul held high -> mul_start on cycle 0 only, stall_ex=1 for cycles 0..3, mul_done=1 on cycle 4 with stalls 0; cnt_freeze=4.
- Mul with dcache_stall raised at cycle 3 for 3 cycles -> DONE held, mul_done asserted only on the first cycle after dcache_stall drops; stalls continuous throughout.
- Back-to-back muls (ex_mul stays 1 after DONE) -> second mul_start the cycle after mul_done; no double start for the first mul.
- icache_stall concurrent with ex_mispredict for 2 cycles -> redirect_valid=0 during stall, then 1 on the first unfrozen cycle; rst_n pulsed during BUSY -> FSM IDLE, all outputs 0, counters 0.
